// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver, the counterpart of the team's UART
// transmitter. Receives 1 start bit, 8 data bits (LSB first), an optional
// odd/even parity bit and 1 stop bit. Each byte is presented with a valid
// strobe and per-frame parity and framing error flags.
//
// Ports:
//   clk          system clock
//   a_resetn     asynchronous reset, active-high (despite the name)
//   b_tick       one-clk pulse at OVERSAMPLE x baud rate
//   rx           asynchronous serial input, idles high
//   parity       00/11 none, 01 odd, 10 even; latched at start-bit confirmation
//   rx_data      last received byte, held until the next frame completes
//   rx_valid     one-clk pulse per completed frame (a level with UART_RX_HOLD_EN)
//   parity_err   parity error for rx_data, held with rx_data
//   frame_err    stop bit sampled low, held with rx_data
//   rx_ack       (UART_RX_HOLD_EN only) consumer acknowledge of rx_valid
//   overrun_err  (UART_RX_HOLD_EN only) a frame completed while rx_valid was set
//
// Optional feature macro: UART_RX_HOLD_EN.

module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 a_resetn,
  input  logic                 b_tick,
  input  logic                 rx,
  input  logic [1:0]           parity,
`ifdef UART_RX_HOLD_EN
  input  logic                 rx_ack,
  output logic                 overrun_err,
`endif
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // The start check happens on the tick that brings the count to
  // OVERSAMPLE/2-1, i.e. while the count still holds OVERSAMPLE/2-2.
  localparam logic [3:0] START_CHK = 4'(OVERSAMPLE / 2 - 2);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  state_t               state;
  logic [3:0]           tick_cnt;
  logic [2:0]           bit_idx;
  logic                 armed;
  logic [1:0]           par_mode;
  logic                 par_err;
  logic [DATA_BITS-1:0] shift;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 has_parity;

  assign has_parity = (par_mode == 2'b01) || (par_mode == 2'b10);

  // Two-flop synchroniser; resets to the idle (high) line level so a reset
  // never looks like a start edge.
  always_ff @(posedge clk or posedge a_resetn) begin
    if (a_resetn) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge a_resetn) begin
    if (a_resetn) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      armed      <= 1'b0;
      par_mode   <= 2'b00;
      par_err    <= 1'b0;
      shift      <= '0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
`ifdef UART_RX_HOLD_EN
      overrun_err <= 1'b0;
`endif
    end else begin
`ifdef UART_RX_HOLD_EN
      // Acknowledge clears the level; a completion later in this block wins.
      if (rx_valid && rx_ack) begin
        rx_valid    <= 1'b0;
        overrun_err <= 1'b0;
      end
`else
      rx_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // Only a high-to-low edge may start a frame; a line left low after
          // a framing error must first return high.
          if (rx_s) begin
            armed <= 1'b1;
          end
          if (armed && !rx_s) begin
            tick_cnt <= '0;
            state    <= START;
          end
        end

        START: begin
          if (b_tick) begin
            if (tick_cnt == START_CHK) begin
              if (rx_s) begin
                state <= IDLE;
              end else begin
                par_mode <= parity;
                par_err  <= 1'b0;
                tick_cnt <= '0;
                bit_idx  <= '0;
                state    <= DATA;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end

        DATA: begin
          if (b_tick) begin
            if (tick_cnt == LAST_TICK) begin
              shift[bit_idx] <= rx_s;
              tick_cnt       <= '0;
              bit_idx        <= bit_idx + 3'd1;
              if (bit_idx == LAST_BIT) begin
                state <= has_parity ? PARITY : STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end

        PARITY: begin
          if (b_tick) begin
            if (tick_cnt == LAST_TICK) begin
              // Even mode flags an odd total; odd mode inverts that.
              par_err  <= (^shift) ^ rx_s ^ (par_mode == 2'b01);
              tick_cnt <= '0;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end

        STOP: begin
          if (b_tick) begin
            if (tick_cnt == LAST_TICK) begin
              rx_data    <= shift;
              frame_err  <= ~rx_s;
              parity_err <= has_parity ? par_err : 1'b0;
              rx_valid   <= 1'b1;
              armed      <= rx_s;
              tick_cnt   <= '0;
              state      <= IDLE;
`ifdef UART_RX_HOLD_EN
              overrun_err <= rx_valid && !rx_ack;
`endif
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. Frames are driven bit by bit
// with 16 b_tick pulses per bit; a frame-level model predicts the held byte
// and flags, and a compare process checks them on every clock edge.
// Build with UART_RX_HOLD_EN defined to also exercise the hold/ack mode.

module tb_uart_rx;

  logic       clk = 1'b0;
  logic       a_resetn;
  logic       b_tick;
  logic       rx;
  logic [1:0] parity;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       frame_err;
`ifdef UART_RX_HOLD_EN
  logic       rx_ack;
  logic       overrun_err;
`endif

  int total = 0;
  int bad   = 0;

  // Frame-level model of what the outputs must hold.
  logic [7:0] exp_data;
  logic       exp_perr;
  logic       exp_ferr;
  logic       exp_valid;
  logic       exp_ovr;
  bit         settle  = 1'b0;
  bit         started = 1'b0;
  int         valid_seen = 0;

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk        (clk),
    .a_resetn   (a_resetn),
    .b_tick     (b_tick),
    .rx         (rx),
    .parity     (parity),
`ifdef UART_RX_HOLD_EN
    .rx_ack     (rx_ack),
    .overrun_err(overrun_err),
`endif
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Outputs must match the model on every edge except the few clocks where
  // a frame is landing or an ack is being taken.
  always @(negedge clk) begin
    if (started && !settle) begin
      checkOutput("held_data", 32'(rx_data), 32'(exp_data));
      checkOutput("held_perr", 32'(parity_err), 32'(exp_perr));
      checkOutput("held_ferr", 32'(frame_err), 32'(exp_ferr));
`ifdef UART_RX_HOLD_EN
      checkOutput("held_valid", 32'(rx_valid), 32'(exp_valid));
      checkOutput("held_ovr", 32'(overrun_err), 32'(exp_ovr));
`else
      checkOutput("quiet_valid", 32'(rx_valid), 32'(exp_valid));
`endif
    end else if (started && settle && rx_valid) begin
      valid_seen++;
    end
  end

  task automatic tick_once();
    @(negedge clk) b_tick = 1'b1;
    @(negedge clk) b_tick = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) tick_once();
  endtask

  task automatic model_reset();
    exp_data  = 8'h00;
    exp_perr  = 1'b0;
    exp_ferr  = 1'b0;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
  endtask

  // Sends one complete frame and moves the model on at the mid-stop tick.
  task automatic applyStimulus(input logic [7:0] data, input logic [1:0] mode,
                               input logic pbit, input logic stopb);
    bit has_par;
    int ones;
    int v0;
    logic perr;
    has_par = (mode == 2'b01) || (mode == 2'b10);
    ones    = $countones(data) + int'(pbit);
    perr    = has_par && ((mode == 2'b01) ? (ones % 2 == 0) : (ones % 2 == 1));
    parity  = mode;
    drive_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) drive_bit(data[i], 16);
    if (has_par) drive_bit(pbit, 16);
    drive_bit(stopb, 7);
    v0     = valid_seen;
    settle = 1'b1;
    tick_once();
    exp_data = data;
    exp_perr = perr;
    exp_ferr = !stopb;
`ifdef UART_RX_HOLD_EN
    exp_ovr   = exp_valid;
    exp_valid = 1'b1;
`else
    checkOutput("valid_pulse", 32'(valid_seen - v0), 32'd1);
`endif
    settle = 1'b0;
    repeat (8) tick_once();
  endtask

`ifdef UART_RX_HOLD_EN
  task automatic ack_pulse();
    settle = 1'b1;
    @(negedge clk) rx_ack = 1'b1;
    @(negedge clk) rx_ack = 1'b0;
    checkOutput("ack_valid", 32'(rx_valid), 32'd0);
    checkOutput("ack_ovr", 32'(overrun_err), 32'd0);
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    settle    = 1'b0;
  endtask
`endif

  initial begin
    a_resetn = 1'b1;
    b_tick   = 1'b0;
    rx       = 1'b1;
    parity   = 2'b00;
`ifdef UART_RX_HOLD_EN
    rx_ack   = 1'b0;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    #2 a_resetn = 1'b0;
    started = 1'b1;
    @(negedge clk);

    // Idle line after reset: nothing received.
    drive_bit(1'b1, 32);
    checkOutput("reset_data", 32'(rx_data), 32'h0);
    checkOutput("reset_valid", 32'(rx_valid), 32'h0);
    checkOutput("reset_perr", 32'(parity_err), 32'h0);
    checkOutput("reset_ferr", 32'(frame_err), 32'h0);

    // No parity.
    applyStimulus(8'hA5, 2'b00, 1'b0, 1'b1);
    checkOutput("a5_data", 32'(rx_data), 32'hA5);
    checkOutput("a5_perr", 32'(parity_err), 32'h0);
    checkOutput("a5_ferr", 32'(frame_err), 32'h0);

    // Even parity: 0x07 has three ones, so parity bit 1 is correct.
    applyStimulus(8'h07, 2'b10, 1'b1, 1'b1);
    checkOutput("even_ok_perr", 32'(parity_err), 32'h0);
    applyStimulus(8'h07, 2'b10, 1'b0, 1'b1);
    checkOutput("even_bad_perr", 32'(parity_err), 32'h1);
    checkOutput("even_bad_data", 32'(rx_data), 32'h07);

    // Mode 11 behaves as no parity.
    applyStimulus(8'h5A, 2'b11, 1'b0, 1'b1);
    checkOutput("none11_data", 32'(rx_data), 32'h5A);
    checkOutput("none11_perr", 32'(parity_err), 32'h0);

    // Odd parity with a low stop bit, then a stuck-low line.
    applyStimulus(8'h3C, 2'b01, 1'b1, 1'b0);
    checkOutput("ferr_flag", 32'(frame_err), 32'h1);
    checkOutput("ferr_data", 32'(rx_data), 32'h3C);
    checkOutput("ferr_perr", 32'(parity_err), 32'h0);
    drive_bit(1'b0, 48);
    drive_bit(1'b1, 16);

    // Start glitch of 4 ticks is rejected; the next frame still works.
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 32);
    applyStimulus(8'hC3, 2'b01, 1'b1, 1'b1);
    checkOutput("post_glitch_data", 32'(rx_data), 32'hC3);
    checkOutput("post_glitch_ferr", 32'(frame_err), 32'h0);

    // Reset in the middle of data bit 3 discards the frame.
    parity = 2'b00;
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b0, 16);
    drive_bit(1'b1, 16);
    drive_bit(1'b1, 8);
    @(negedge clk);
    #2 a_resetn = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    checkOutput("midreset_data", 32'(rx_data), 32'h0);
    checkOutput("midreset_valid", 32'(rx_valid), 32'h0);
    checkOutput("midreset_ferr", 32'(frame_err), 32'h0);
    @(negedge clk);
    #2 a_resetn = 1'b0;
    @(negedge clk);
    drive_bit(1'b1, 32);
    applyStimulus(8'h96, 2'b00, 1'b0, 1'b1);
    checkOutput("recover_data", 32'(rx_data), 32'h96);

`ifdef UART_RX_HOLD_EN
    ack_pulse();
    applyStimulus(8'h11, 2'b00, 1'b0, 1'b1);
    applyStimulus(8'h22, 2'b00, 1'b0, 1'b1);
    checkOutput("hold_data22", 32'(rx_data), 32'h22);
    checkOutput("hold_ovr", 32'(overrun_err), 32'h1);
    checkOutput("hold_valid_lvl", 32'(rx_valid), 32'h1);
    ack_pulse();
`endif

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; counterpart of the team's 16x-oversampled UART transmitter.
- Deserialises 1 start bit, 8 data bits (LSB first), an optional odd/even parity bit and 1 stop bit from the serial line.
- Presents each received byte with a valid strobe and per-frame parity/framing error flags.
- Sits between the pad-side rx line and the AXI-Lite RX FIFO write port.

Parameters:
- OVERSAMPLE, 16, b_tick pulses per bit period; must be even and at least 4.
- DATA_BITS, 8, data bits per frame; fixed at 8 for this block.

Ports:
- clk  in  1  system clock (50 MHz).
- a_resetn  in  1  reset; asynchronous, active-high (despite the name).
- b_tick  in  1  one-clk pulse at 16x baud rate (50e6/16/115200).
- rx  in  1  asynchronous serial input; idles high.
- parity  in  2  mode: 00 none, 01 odd, 10 even, 11 none. Sampled at start-bit confirmation.
- rx_data  out  8  last received byte; holds until the next frame completes.
- rx_valid  out  1  one-clk pulse when a frame completes.
- parity_err  out  1  parity error for the current rx_data; valid with rx_valid, held with rx_data.
- frame_err  out  1  stop bit sampled low; valid with rx_valid, held with rx_data.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, state=IDLE, tick counter=0, bit index=0, armed=0. Synchroniser flops reset to 1.
- Input synchronisation: rx passes through a 2-flop synchroniser (rx_s). All decisions use rx_s, giving 2 clk of latency.
- Tick counter: 4-bit, advances only on b_tick. States with no b_tick hold all counters.
- armed flag: set when rx_s==1 in IDLE. This prevents a stuck-low line or break from retriggering after a frame error.
- IDLE: when armed and rx_s==0, clear the tick counter and go to START.
- START: on the b_tick that makes the count OVERSAMPLE/2-1 (mid-bit), check rx_s.
  - rx_s==1 (glitch): return to IDLE, no outputs change.
  - rx_s==0: latch parity mode, clear the tick counter and bit index, go to DATA.
- DATA: on each b_tick with count==OVERSAMPLE-1, sample rx_s into shift[bit index], clear the count and increment the index.
  - After index 7 is sampled: go to PARITY if mode is 01 or 10, otherwise go to STOP.
- PARITY: sample rx_s at count==OVERSAMPLE-1.
  - Odd mode: error if XOR(data,bit)==0.
  - Even mode: error if XOR(data,bit)==1.
- STOP: sample rx_s at count==OVERSAMPLE-1. On that same clk:
  - rx_data<=shift.
  - frame_err<=~rx_s.
  - parity_err<=computed error, or 0 when no parity.
  - rx_valid<=1 for exactly one clk.
  - armed<=rx_s.
  - Go to IDLE.
- Frame-end timing: the frame completes at mid-stop. A new start edge is accepted from the next clk onward if the line is high then low.
- Reset mid-frame: the frame is discarded, no rx_valid is issued, and all outputs return to their reset values immediately.
- b_tick and a state change in the same clk: the state transition uses that tick. No tick is lost or double-counted.
- Illegal state encoding: go to IDLE.

Optional Feature:
- Macro: UART_RX_HOLD_EN.
- When defined:
  - Adds input rx_ack (1) and output overrun_err (1, reset 0).
  - rx_valid becomes a level: set at frame completion, cleared on the clk after rx_ack==1 while rx_valid==1.
  - If a frame completes while rx_valid is still 1: rx_data is overwritten, overrun_err<=1, rx_valid stays 1.
  - overrun_err clears together with rx_valid on ack.
  - If ack and completion happen in the same clk, completion wins: rx_valid stays 1 and no overrun is flagged.
- When undefined: neither port exists, and rx_valid is the one-clk pulse described above.

Test Plan:
- Reset, then rx=1 for 2 bit times → all outputs 0, no rx_valid.
- Parity=00, send 0xA5 with stop=1 → exactly one rx_valid pulse; rx_data=0xA5, parity_err=0, frame_err=0. Pulse lands within 2 clk of the mid-stop tick.
- Parity=10 (even), send 0x07 with parity bit 1 → parity_err=0. Repeat with parity bit 0 → parity_err=1, rx_data=0x07.
- Parity=01 (odd), send 0x3C with stop bit driven 0 → frame_err=1. Hold rx low for 3 bit times → no further frames until rx returns high.
- rx low pulse of 4 ticks (glitch), then idle → no rx_valid; state back to IDLE. Assert a_resetn during data bit 3 → no rx_valid and outputs 0.
- Define UART_RX_HOLD_EN, send 0x11 then 0x22 without rx_ack → rx_data=0x22, overrun_err=1. Pulse rx_ack → rx_valid=0 and overrun_err=0 on the next clk.
